// File: rtl/ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage
//
// Purpose
//   Elastic EX->MEM pipeline register. It sits between the ALU/branch-adder
//   outputs and the data-memory / writeback control. It has a valid/ready
//   handshake, back-pressure, flush-to-bubble and an optional 2-entry skid
//   buffer.
//
// Configuration macro
//   EX_MEM_SKID_EN  defined   : 2-entry skid buffer. in_ready comes straight
//                               from a flop, with no path from out_ready.
//                   undefined : single entry. in_ready = ~out_valid | out_ready.
//
// Ports
//   clk              in   rising-edge clock
//   reset_n          in   asynchronous assert, active-low reset
//   flush            in   kill every held entry; a same-cycle input is dropped
//   in_valid/in_ready     EX-side handshake
//   in_target        in   branch target            [XLEN]
//   in_result        in   ALU result               [XLEN]
//   in_store_data    in   rs2 store data           [XLEN]
//   in_zero          in   ALU zero flag
//   in_rd            in   destination register     [REG_ADDR_W]
//   in_funct3        in   funct3                   [3]
//   in_ctrl          in   {Branch,MemWrite,MemRead,MemtoReg,RegWrite} [CTRL_W]
//   out_valid/out_ready   MEM-side handshake
//   out_*            out  registered copies of in_*. out_ctrl is gated by
//                         out_valid.
// ---------------------------------------------------------------------------
module ex_mem_pipe_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_target,
  input  logic [XLEN-1:0]       in_result,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic                  in_zero,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [2:0]            in_funct3,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_target,
  output logic [XLEN-1:0]       out_result,
  output logic [XLEN-1:0]       out_store_data,
  output logic                  out_zero,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [2:0]            out_funct3,
  output logic [CTRL_W-1:0]     out_ctrl
);

  localparam int PW = 3*XLEN + 1 + REG_ADDR_W + 3 + CTRL_W;

  logic [PW-1:0]     in_payload;
  logic [PW-1:0]     main_reg;
  logic [CTRL_W-1:0] ctrl_raw;
  logic              out_valid_int;
  logic              accept;
  logic              drain;

  assign in_payload = {in_target, in_result, in_store_data, in_zero,
                       in_rd, in_funct3, in_ctrl};

  assign {out_target, out_result, out_store_data, out_zero,
          out_rd, out_funct3, ctrl_raw} = main_reg;

  // A bubble must never assert RegWrite/MemRead/MemWrite/Branch downstream.
  // The other fields keep their stale value because nothing reads them
  // while the entry is invalid.
  assign out_ctrl  = ctrl_raw & {CTRL_W{out_valid_int}};
  assign out_valid = out_valid_int;

`ifdef EX_MEM_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [PW-1:0] skid_reg;
  logic          in_ready_reg;
  logic          load_main_in;
  logic          load_main_skid;
  logic          load_skid;

  assign out_valid_int = (state_reg != ST_EMPTY);
  assign in_ready      = in_ready_reg;
  assign accept        = in_valid & in_ready_reg & ~flush;
  assign drain         = out_valid_int & out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // A same-cycle drain has already been seen by MEM. Everything else is
      // dropped.
      state_next = ST_EMPTY;
    end else begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            // The consumer stalled after in_ready was already promised, so
            // the incoming entry parks in the skid register.
            state_next = ST_SKID;
            load_skid  = 1'b1;
          end else if (drain) begin
            state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drain) begin
            state_next     = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      // Registering in_ready from the next state removes every
      // combinational path from out_ready to in_ready.
      in_ready_reg <= (state_next != ST_SKID);
      if (load_main_in) begin
        main_reg <= in_payload;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= in_payload;
      end
    end
  end

`else

  logic valid_reg;

  assign out_valid_int = valid_reg;
  assign in_ready      = ~valid_reg | out_ready;
  assign accept        = in_valid & in_ready & ~flush;
  assign drain         = valid_reg & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      main_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      main_reg  <= in_payload;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_stage
//
// Directed and random stimulus for ex_mem_pipe_stage. A queue-based reference
// model describes the stage as a FIFO with capacity 1 (no skid) or 2 (skid).
// Entries are accepted when ready and not flushed, popped on drain, and the
// whole queue is cleared on flush or reset.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_stage;

`ifdef EX_MEM_SKID_EN
  localparam bit HAS_SKID = 1'b1;
`else
  localparam bit HAS_SKID = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] target;
    logic [63:0] result;
    logic [63:0] store_data;
    logic        zero;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  ctrl;
  } item_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_target;
  logic [63:0] in_result;
  logic [63:0] in_store_data;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_target;
  logic [63:0] out_result;
  logic [63:0] out_store_data;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_ctrl;

  int    n_cmp = 0;
  int    n_bad = 0;
  item_t model_q[$];

  always #5 clk = ~clk;

  ex_mem_pipe_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_target     (in_target),
    .in_result     (in_result),
    .in_store_data (in_store_data),
    .in_zero       (in_zero),
    .in_rd         (in_rd),
    .in_funct3     (in_funct3),
    .in_ctrl       (in_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_target    (out_target),
    .out_result    (out_result),
    .out_store_data(out_store_data),
    .out_zero      (out_zero),
    .out_rd        (out_rd),
    .out_funct3    (out_funct3),
    .out_ctrl      (out_ctrl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t rand_item(input logic [63:0] result);
    item_t it;
    it.target     = {$urandom, $urandom};
    it.result     = result;
    it.store_data = {$urandom, $urandom};
    it.zero       = 1'($urandom_range(0, 1));
    it.rd         = 5'($urandom_range(8, 31));  // rd 7 is reserved for the flush test
    it.funct3     = 3'($urandom_range(0, 7));
    it.ctrl       = 5'($urandom_range(0, 31));
    return it;
  endfunction

  // One clock cycle: drive inputs just after the edge, check mid-cycle, then
  // advance the model to what the next edge should commit.
  task automatic step(input bit v, input bit ordy, input bit fl, input item_t it);
    bit exp_ready;
    bit exp_valid;
    bit drn;
    bit acc;
    @(posedge clk);
    #1;
    in_valid      = v;
    out_ready     = ordy;
    flush         = fl;
    in_target     = it.target;
    in_result     = it.result;
    in_store_data = it.store_data;
    in_zero       = it.zero;
    in_rd         = it.rd;
    in_funct3     = it.funct3;
    in_ctrl       = it.ctrl;
    #3;
    exp_valid = (model_q.size() > 0);
    exp_ready = HAS_SKID ? (model_q.size() < 2) : (!exp_valid || ordy);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("in_ready",  64'(in_ready),  64'(exp_ready));
    if (exp_valid) begin
      chk("out_ctrl",       64'(out_ctrl),   64'(model_q[0].ctrl));
      chk("out_result",     out_result,      model_q[0].result);
      chk("out_target",     out_target,      model_q[0].target);
      chk("out_store_data", out_store_data,  model_q[0].store_data);
      chk("out_rd",         64'(out_rd),     64'(model_q[0].rd));
      chk("out_funct3",     64'(out_funct3), 64'(model_q[0].funct3));
      chk("out_zero",       64'(out_zero),   64'(model_q[0].zero));
    end else begin
      chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    end
    drn = exp_valid && ordy;
    acc = v && exp_ready && !fl;
    if (fl) begin
      model_q.delete();
    end else begin
      if (drn) void'(model_q.pop_front());
      if (acc) model_q.push_back(it);
    end
    $display("cyc v=%0b rdy=%0b fl=%0b res=%0h -> out_v=%0b out_res=%0h q=%0d",
             v, ordy, fl, it.result, out_valid, out_result, model_q.size());
  endtask

  initial begin
    item_t it;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    it        = rand_item(64'h55);
    in_target = it.target;  in_result = it.result;  in_store_data = it.store_data;
    in_zero   = it.zero;    in_rd     = it.rd;      in_funct3     = it.funct3;
    in_ctrl   = it.ctrl;

    // Reset held while the input is valid.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_ctrl",   64'(out_ctrl),   64'd0);
    chk("rst_out_result", out_result,      64'd0);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back stream, result = k.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 1'b0, rand_item(64'(k)));
    repeat (2) step(1'b0, 1'b1, 1'b0, rand_item(64'h0));

    // Stall for 3 cycles in the middle of a stream.
    for (int k = 16; k < 19; k++) step(1'b1, 1'b1, 1'b0, rand_item(64'(k)));
    for (int k = 19; k < 22; k++) step(1'b1, 1'b0, 1'b0, rand_item(64'(k)));
    for (int k = 22; k < 26; k++) step(1'b1, 1'b1, 1'b0, rand_item(64'(k)));
    repeat (3) step(1'b0, 1'b1, 1'b0, rand_item(64'h0));

    // Fill to capacity, then flush with a valid rd=7 input.
    repeat (3) step(1'b1, 1'b0, 1'b0, rand_item(64'h30));
    it    = rand_item(64'h77);
    it.rd = 5'd7;
    step(1'b1, 1'b0, 1'b1, it);
    repeat (3) step(1'b0, 1'b1, 1'b0, rand_item(64'h0));

    // Drain and flush in the same cycle.
    step(1'b1, 1'b0, 1'b0, rand_item(64'h40));
    step(1'b0, 1'b1, 1'b1, rand_item(64'h41));
    step(1'b0, 1'b1, 1'b0, rand_item(64'h0));

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0), rand_item({$urandom, $urandom}));
    end

    // Reset pulsed while the stage is full.
    repeat (3) step(1'b1, 1'b0, 1'b0, rand_item(64'h60));
    reset_n  = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_ctrl",  64'(out_ctrl),  64'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, rand_item(64'hABC));
    step(1'b1, 1'b1, 1'b0, rand_item(64'hABD));
    repeat (2) step(1'b0, 1'b1, 1'b0, rand_item(64'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
